// File: rtl/rvspec_stream_checker.sv
// Retirement-stream checker: replays a shadow register file and expected PC
// against offered retirement records and latches the first mismatch.
// Ports: clock/resetn (sync, active-low); init_* loads shadow regs in IDLE;
// start leaves IDLE; in_* record stream with in_valid/in_ready handshake;
// err/err_code/err_index report the first failure; count/done track progress.
module rvspec_stream_checker #(
  parameter int unsigned          XLEN      = 32,
  parameter int                   NREGS     = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter logic [XLEN-1:0]      TRAP_PC   = '0,
  parameter int                   MAX_INSNS = 1024,
  localparam int                  CW        = $clog2(MAX_INSNS + 1)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            init_we,
  input  logic [4:0]      init_addr,
  input  logic [XLEN-1:0] init_data,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_npc,
  input  logic            in_trap,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_rdata,
  input  logic [XLEN-1:0] in_rs2_rdata,
  input  logic [XLEN-1:0] in_rd_wdata,
  output logic            err,
  output logic [2:0]      err_code,
  output logic [CW-1:0]   err_index,
  output logic [CW-1:0]   count,
  output logic            done
);

  localparam int AW = $clog2(NREGS);
  localparam logic [CW-1:0] MAXC = CW'(MAX_INSNS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] shadow_q [NREGS];
  logic [XLEN-1:0] shadow_d [NREGS];
  logic [XLEN-1:0] epc_q, epc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [2:0]      code_q, code_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;

  logic [2:0]      chk_code;
  logic [CW-1:0]   cnt_inc;
  logic            rs1_ok, rs2_ok, rd_ok, ia_ok;

  function automatic logic in_rng(input logic [4:0] a);
    return int'(a) < NREGS;
  endfunction

  assign rs1_ok = in_rng(in_rs1_addr);
  assign rs2_ok = in_rng(in_rs2_addr);
  assign rd_ok  = in_rng(in_rd_addr);
  assign ia_ok  = in_rng(init_addr);

  // Entry 0 is held at zero forever, so a direct
  // lookup already gives x0 == 0.
  always_comb begin
    chk_code = 3'd0;
    if (in_pc != epc_q)
      chk_code = 3'd1;
    else if (!rs1_ok ||
             in_rs1_rdata != shadow_q[in_rs1_addr[AW-1:0]])
      chk_code = 3'd2;
    else if (!rs2_ok ||
             in_rs2_rdata != shadow_q[in_rs2_addr[AW-1:0]])
      chk_code = 3'd3;
    else if (!in_trap && !rd_ok)
      chk_code = 3'd4;
    else if (!in_trap && in_npc[1:0] != 2'b00)
      chk_code = 3'd5;
  end

  assign cnt_inc = (cnt_q == MAXC) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    epc_d    = epc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    code_d   = code_q;
    idx_d    = idx_q;
    done_d   = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (init_we && init_addr != 5'd0 && ia_ok)
          shadow_d[init_addr[AW-1:0]] = init_data;
        if (start)
          state_d = S_RUN;
      end
      S_RUN: begin
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (chk_code != 3'd0) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            code_d  = chk_code;
            idx_d   = cnt_q;
          end else begin
            if (in_trap) begin
              epc_d = TRAP_PC;
            end else begin
              if (in_rd_addr != 5'd0)
                shadow_d[in_rd_addr[AW-1:0]] = in_rd_wdata;
              epc_d = in_npc;
            end
            if (cnt_inc == MAXC) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NREGS; i++)
        shadow_q[i] <= '0;
      epc_q  <= RESET_PC;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      code_q <= 3'd0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NREGS; i++)
        shadow_q[i] <= shadow_d[i];
      epc_q  <= epc_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      code_q <= code_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  assign in_ready  = (state_q == S_RUN);
  assign err       = err_q;
  assign err_code  = code_q;
  assign err_index = idx_q;
  assign count     = cnt_q;
  assign done      = done_q;

endmodule

// File: doc/rvspec_stream_checker.md
RVSPEC_STREAM_CHECKER -- requirements
Module: rvspec_stream_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32: register, PC and data width.
REQ-002 SHALL have parameter NREGS, default 32: architectural register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: expected PC of the first checked record.
REQ-004 SHALL have parameter TRAP_PC, default 32'h0: expected PC of the record following a trapping record.
REQ-005 SHALL have parameter MAX_INSNS, default 1024: count of accepted records after which checking completes.
REQ-006 SHALL have ports: clock  in  1  sole clock, rising edge; resetn  in  1  synchronous reset, active-low.
REQ-007 SHALL have ports: init_we  in  1  shadow write strobe; init_addr  in  5  shadow index; init_data  in  XLEN  shadow value.
REQ-008 SHALL have port: start  in  1  pulse that leaves IDLE.
REQ-009 SHALL have ports: in_valid  in  1  record offered; in_ready  out  1  record accepted when high with in_valid.
REQ-010 SHALL have ports: in_pc, in_npc  in  XLEN; in_trap  in  1; in_rs1_addr, in_rs2_addr, in_rd_addr  in  5; in_rs1_rdata, in_rs2_rdata, in_rd_wdata  in  XLEN.
REQ-011 SHALL have ports: err  out  1  sticky mismatch flag; err_code  out  3; err_index  out  $clog2(MAX_INSNS+1); count  out  $clog2(MAX_INSNS+1)  accepted records; done  out  1.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE, ERROR.
REQ-013 SHALL keep shadow registers x1..x(NREGS-1); x0 SHALL read as zero and never be written.
REQ-014 In IDLE only, init_we with init_addr in 1..NREGS-1 SHALL write init_data into the shadow register at that edge; other addresses, or init_we outside IDLE, SHALL be ignored.
REQ-015 IDLE -> RUN on start; start outside IDLE SHALL be ignored; init_we and start together in IDLE SHALL perform the write and the transition.
REQ-016 in_ready SHALL equal (state == RUN), combinationally.
REQ-017 An accepted record SHALL be checked combinationally against the current shadow state and expected PC; the verdict SHALL be registered, so err rises one cycle after the accepting edge.
REQ-018 Check codes, lowest number wins if several fail: 1 in_pc != expected PC; 2 in_rs1_rdata != shadow[in_rs1_addr]; 3 in_rs2_rdata != shadow[in_rs2_addr]; 4 !in_trap and in_rd_addr >= NREGS; 5 !in_trap and in_npc[1:0] != 0.
REQ-019 Codes 2 and 3 SHALL also fire if the respective source address >= NREGS.
REQ-020 On a passing non-trap record: shadow[in_rd_addr] <= in_rd_wdata (rd != 0); expected PC <= in_npc.
REQ-021 On a passing trap record: no shadow write; expected PC <= TRAP_PC.
REQ-022 Shadow and expected-PC updates SHALL occur at the accepting edge, so a back-to-back record in the next cycle sees them (no bubble, no hazard).
REQ-023 On a failing record: no shadow or PC update; state -> ERROR; err_code <= code; err_index <= count before increment.
REQ-024 count SHALL increment on every accepted record, passing or failing, saturating at MAX_INSNS.
REQ-025 When count reaches MAX_INSNS on a passing record, state -> DONE and done <= 1 at that edge.
REQ-026 ERROR and DONE SHALL be terminal until reset; in_ready low; err, err_code, err_index, done frozen.

Reset
REQ-027 When resetn is low at a rising edge: state IDLE; all shadow registers 0; expected PC RESET_PC; count 0; err 0; err_code 0; err_index 0; done 0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-stream in RUN; any record offered in that cycle SHALL NOT be accepted.

Verification
REQ-029 Init x5=32'h1234, start; record pc=0, rs1=5, rs1_rdata=32'h1234, rd=6, rd_wdata=7, npc=4 -> err 0; next record rs1=6, rs1_rdata=7, pc=4 back-to-back -> err 0, count 2.
REQ-030 Record pc=8 when expected 4 with rs1 data also wrong -> next cycle err=1, err_code=1, err_index=1; in_ready 0 thereafter.
REQ-031 NREGS=16: record rd=20, in_trap=0 -> err_code 4; same with in_trap=1 and in_npc arbitrary -> pass, next expected PC = TRAP_PC.
REQ-032 MAX_INSNS=4: four passing records -> done=1 after the fourth, in_ready 0; fifth in_valid is not accepted, count stays 4.
REQ-033 Record with rd=0, rd_wdata=32'hFFFF_FFFF, then rs1=0 rs1_rdata=0 -> no error (x0 stays zero).
REQ-034 resetn low in RUN with in_valid high -> record not accepted; next cycle state IDLE, count 0, shadow all zero.
